pattern_detector: RTL and testbench
===================================

# pattern_detector

Compares the pre-register ALU result against a 48-bit pattern under a mask and produces pattern-match and inverted-pattern-match flags. It sits directly upstream of the P output register stage: raw flags drive that stage's auto-reset inputs in the same cycle, and registered flags, one-cycle history and overflow/underflow go to the slice outputs. Pattern, mask and mode are loaded through the slice's serial configuration chain.

## Interface
- `input_freezed`, default 1'b0: when 1, behaves as if PREG=1 regardless of the PREG pin.

- `clk` input 1: sole clock, rising edge.
- `RSTN` input 1: synchronous active-low reset of flag/history registers.
- `CEP` input 1: clock enable for flag and history registers.
- `PREG` input 1: 1 = registered flag outputs, 0 = combinational.
- `inter_P` input 48: ALU result, the same value the output stage registers.
- `C` input 48: C operand, used as dynamic pattern or mask source.
- `PATDET_RAW` output 1: combinational match, feeds output stage PATTERNDETECT.
- `PATBDET_RAW` output 1: combinational inverted match, feeds output stage PATTERNBDETECT.
- `PATTERNDETECT`, `PATTERNBDETECT` output 1 each: slice-level flags.
- `PATTERNDETECTPAST`, `PATTERNBDETECTPAST` output 1 each: flags delayed one enabled cycle.
- `OVERFLOW`, `UNDERFLOW` output 1 each: saturation indicators.
- `configuration_input` input 1, `configuration_enable` input 1, `configuration_output` output 1: serial configuration chain.

## Operation
- Config registers: USE_PATTERN_DETECT, SEL_PATTERN (0 = PATTERN reg, 1 = C), SEL_MASK (0 = MASK reg, 1 = C), PATTERN[47:0], MASK[47:0]; 99 bits.
- Shift on clk when configuration_enable=1: USE_PATTERN_DETECT <= configuration_input; SEL_PATTERN <= USE_PATTERN_DETECT; SEL_MASK <= SEL_PATTERN; PATTERN[0] <= SEL_MASK; PATTERN[i] <= PATTERN[i-1]; MASK[0] <= PATTERN[47]; MASK[i] <= MASK[i-1]; configuration_output = MASK[47]. First bit shifted lands in MASK[47] after 99 shifts.
- Config registers are not affected by RSTN; chain shifts irrespective of RSTN, CEP.
- pat = SEL_PATTERN ? C : PATTERN; msk = SEL_MASK ? C : MASK (mask bit 1 = don't care).
- PATDET_RAW = USE & (&((inter_P ~^ pat) | msk)); PATBDET_RAW = USE & (&((inter_P ^ pat) | msk)). Both 1 only if msk is all ones.
- Registers pd_r, pbd_r, pd_past, pbd_past: RSTN=0 -> all 0; else if CEP: pd_r<=PATDET_RAW, pbd_r<=PATBDET_RAW, pd_past<=PATTERNDETECT, pbd_past<=PATTERNBDETECT (selected outputs, pre-edge values); else hold.
- Mode M = input_freezed | PREG. M=1: PATTERNDETECT=pd_r, PATTERNBDETECT=pbd_r. M=0: PATTERNDETECT=PATDET_RAW, PATTERNBDETECT=PATBDET_RAW.
- PATTERNDETECTPAST=pd_past, PATTERNBDETECTPAST=pbd_past.
- OVERFLOW = pd_past & ~PATTERNDETECT & ~PATTERNBDETECT; UNDERFLOW = pbd_past & ~PATTERNDETECT & ~PATTERNBDETECT.
- USE_PATTERN_DETECT=0 forces raw flags 0; registers therefore load 0 on next enabled edge.

## Timing
- Raw flags: zero latency, combinational from inter_P, C, config.
- M=1: PATTERNDETECT valid one cycle after the matching inter_P, aligned with the P register load; PAST one further enabled cycle.
- M=0: PATTERNDETECT same cycle; PAST one enabled cycle later.
- Reset values (RSTN=0 at edge): pd_r, pbd_r, pd_past, pbd_past = 0, hence with M=1 all six slice flags 0; OVERFLOW/UNDERFLOW 0.
- RSTN=0 overrides CEP. Reset mid-sequence clears history; OVERFLOW cannot assert on the first enabled cycle after reset.
- CEP=0: all registers hold; combinational outputs still follow inputs (M=0).
- Config shift during operation: raw flags change the cycle after each shift; no protection required.
- PREG change takes effect combinationally on the same cycle.

## Test plan
- Load PATTERN=0, MASK=48'h3FFF_FFFF_FFFF, SEL_*=0, USE=1; PREG=1; inter_P=48'h0000_0000_0005 -> PATDET_RAW=1 same cycle, PATTERNDETECT=1 next cycle, PATTERNDETECTPAST=1 the cycle after.
- Same config; inter_P sequence 0x1, 0x4000_0000_0000 -> cycle after second value OVERFLOW=1 for one cycle; sequence 0xFFFF_FFFF_FFFF, 0xBFFF_FFFF_FFFF -> UNDERFLOW=1 for one cycle.
- SEL_PATTERN=1, MASK=0, C=inter_P=48'hA5A5_A5A5_A5A5 -> PATDET_RAW=1, PATBDET_RAW=0; C=~inter_P -> PATBDET_RAW=1.
- Flags registered at 1, CEP=0 for 3 cycles with inter_P non-matching -> PATTERNDETECT stays 1; then RSTN=0 with CEP=1 -> all flags 0 next edge.
- Shift 99 bits with first bit 1, rest 0 -> configuration_output=1 after 99th shift, USE=0 and raw flags 0 for any inter_P; PREG=0 -> PATTERNDETECT tracks PATDET_RAW combinationally.

Source files
------------

// File: rtl/pattern_detector.sv
// Masked 48-bit pattern / inverted-pattern detector on the pre-register ALU result,
// with registered flags, one-cycle history, overflow/underflow and a 99-bit config chain.
module pattern_detector #(
  parameter bit input_freezed = 1'b0
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic        CEP,
  input  logic        PREG,
  input  logic [47:0] inter_P,
  input  logic [47:0] C,
  output logic        PATDET_RAW,
  output logic        PATBDET_RAW,
  output logic        PATTERNDETECT,
  output logic        PATTERNBDETECT,
  output logic        PATTERNDETECTPAST,
  output logic        PATTERNBDETECTPAST,
  output logic        OVERFLOW,
  output logic        UNDERFLOW,
  input  logic        configuration_input,
  input  logic        configuration_enable,
  output logic        configuration_output
);

  logic        r_use;
  logic        r_sel_pat;
  logic        r_sel_msk;
  logic [47:0] r_pattern;
  logic [47:0] r_mask;

  logic [47:0] w_pat;
  logic [47:0] w_msk;
  logic        w_mode;

  logic        r_pd;
  logic        r_pbd;
  logic        r_pd_past;
  logic        r_pbd_past;

  // Config chain order: input -> USE -> SEL_PATTERN -> SEL_MASK -> PATTERN -> MASK -> output.
  // Not reset and not gated by CEP.
  always_ff @(posedge clk) begin
    if (configuration_enable) begin
      r_use     <= configuration_input;
      r_sel_pat <= r_use;
      r_sel_msk <= r_sel_pat;
      r_pattern <= {r_pattern[46:0], r_sel_msk};
      r_mask    <= {r_mask[46:0], r_pattern[47]};
    end
  end

  assign configuration_output = r_mask[47];

  always_comb begin
    w_pat = r_sel_pat ? C : r_pattern;
    w_msk = r_sel_msk ? C : r_mask;
  end

  // Mask bit 1 = don't care for both the direct and inverted comparison.
  assign PATDET_RAW  = r_use & (&((inter_P ~^ w_pat) | w_msk));
  assign PATBDET_RAW = r_use & (&((inter_P ^  w_pat) | w_msk));

  assign w_mode = input_freezed | PREG;

  assign PATTERNDETECT  = w_mode ? r_pd  : PATDET_RAW;
  assign PATTERNBDETECT = w_mode ? r_pbd : PATBDET_RAW;

  // History captures the selected (mode-dependent) flags, not the raw ones.
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      r_pd       <= 1'b0;
      r_pbd      <= 1'b0;
      r_pd_past  <= 1'b0;
      r_pbd_past <= 1'b0;
    end else if (CEP) begin
      r_pd       <= PATDET_RAW;
      r_pbd      <= PATBDET_RAW;
      r_pd_past  <= PATTERNDETECT;
      r_pbd_past <= PATTERNBDETECT;
    end
  end

  assign PATTERNDETECTPAST  = r_pd_past;
  assign PATTERNBDETECTPAST = r_pbd_past;

  assign OVERFLOW  = r_pd_past  & ~PATTERNDETECT & ~PATTERNBDETECT;
  assign UNDERFLOW = r_pbd_past & ~PATTERNDETECT & ~PATTERNBDETECT;

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector: behavioural model feeds an expected-output
// queue each cycle, plus directed checks of the scenarios of interest.
module tb_pattern_detector;

  logic        clk = 1'b0;
  logic        RSTN, CEP, PREG;
  logic [47:0] inter_P, C;
  logic        PATDET_RAW, PATBDET_RAW, PATTERNDETECT, PATTERNBDETECT;
  logic        PATTERNDETECTPAST, PATTERNBDETECTPAST, OVERFLOW, UNDERFLOW;
  logic        configuration_input, configuration_enable, configuration_output;

  pattern_detector #(.input_freezed(1'b0)) dut (
    .clk(clk), .RSTN(RSTN), .CEP(CEP), .PREG(PREG),
    .inter_P(inter_P), .C(C),
    .PATDET_RAW(PATDET_RAW), .PATBDET_RAW(PATBDET_RAW),
    .PATTERNDETECT(PATTERNDETECT), .PATTERNBDETECT(PATTERNBDETECT),
    .PATTERNDETECTPAST(PATTERNDETECTPAST), .PATTERNBDETECTPAST(PATTERNBDETECTPAST),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
    .configuration_input(configuration_input),
    .configuration_enable(configuration_enable),
    .configuration_output(configuration_output)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic praw, pbraw, pd, pbd, pdp, pbdp, ovf, udf, cout;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Model state: cfg vector is {MASK, PATTERN, SEL_MASK, SEL_PATTERN, USE}
  logic [98:0] m_cfg;
  logic        m_pd, m_pbd, m_pdp, m_pbdp;

  logic [47:0] cur_p, cur_c;
  logic        cur_cep, cur_rstn, cur_preg;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t        e;
    logic [47:0] pat, msk;
    logic        pd, pbd, mode;
    pat = m_cfg[1] ? cur_c : m_cfg[50:3];
    msk = m_cfg[2] ? cur_c : m_cfg[98:51];
    pd  = m_cfg[0];
    pbd = m_cfg[0];
    for (int i = 0; i < 48; i++) begin
      if (!msk[i] && cur_p[i] != pat[i]) pd  = 1'b0;
      if (!msk[i] && cur_p[i] == pat[i]) pbd = 1'b0;
    end
    mode    = cur_preg;
    e.praw  = pd;
    e.pbraw = pbd;
    e.pd    = mode ? m_pd  : pd;
    e.pbd   = mode ? m_pbd : pbd;
    e.pdp   = m_pdp;
    e.pbdp  = m_pbdp;
    e.ovf   = m_pdp  & ~e.pd & ~e.pbd;
    e.udf   = m_pbdp & ~e.pd & ~e.pbd;
    e.cout  = m_cfg[98];
    return e;
  endfunction

  // One clock: drive at negedge, compare expected queue entry, advance model at posedge.
  task automatic cyc(input logic en, input logic din, input logic do_chk);
    exp_t e, got;
    @(negedge clk);
    inter_P = cur_p; C = cur_c; CEP = cur_cep; RSTN = cur_rstn; PREG = cur_preg;
    configuration_enable = en; configuration_input = din;
    #1;
    e = model_out();
    if (do_chk) sb.push_back(e);
    #1;
    if (do_chk && sb.size() > 0) begin
      got = sb.pop_front();
      chk("sb_patdet_raw",  PATDET_RAW,           got.praw);
      chk("sb_patbdet_raw", PATBDET_RAW,          got.pbraw);
      chk("sb_patdet",      PATTERNDETECT,        got.pd);
      chk("sb_patbdet",     PATTERNBDETECT,       got.pbd);
      chk("sb_patdet_past", PATTERNDETECTPAST,    got.pdp);
      chk("sb_patbdet_past",PATTERNBDETECTPAST,   got.pbdp);
      chk("sb_overflow",    OVERFLOW,             got.ovf);
      chk("sb_underflow",   UNDERFLOW,            got.udf);
      chk("sb_cfg_out",     configuration_output, got.cout);
    end
    @(posedge clk);
    if (!cur_rstn) begin
      m_pd = 1'b0; m_pbd = 1'b0; m_pdp = 1'b0; m_pbdp = 1'b0;
    end else if (cur_cep) begin
      m_pd = e.praw; m_pbd = e.pbraw; m_pdp = e.pd; m_pbdp = e.pbd;
    end
    if (en) m_cfg = {m_cfg[97:0], din};
    #2;
  endtask

  task automatic load_cfg(input logic [98:0] v, input logic do_chk);
    for (int i = 98; i >= 0; i--) cyc(1'b1, v[i], do_chk);
  endtask

  function automatic logic [98:0] mk_cfg(input logic [47:0] msk, input logic [47:0] pat,
                                         input logic selm, input logic selp, input logic use_pd);
    return {msk, pat, selm, selp, use_pd};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pd"},   PATTERNDETECT,      1'b0);
    chk({tag, "_pbd"},  PATTERNBDETECT,     1'b0);
    chk({tag, "_pdp"},  PATTERNDETECTPAST,  1'b0);
    chk({tag, "_pbdp"}, PATTERNBDETECTPAST, 1'b0);
    chk({tag, "_ovf"},  OVERFLOW,           1'b0);
    chk({tag, "_udf"},  UNDERFLOW,          1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [98:0] cfg_a, cfg_b, cfg_c, cfg_d;
    logic [47:0] a5;
    cfg_a = mk_cfg(48'h3FFF_FFFF_FFFF, '0, 1'b0, 1'b0, 1'b1);
    cfg_b = mk_cfg('0, '0, 1'b0, 1'b1, 1'b1);
    cfg_c = mk_cfg('0, '0, 1'b1, 1'b0, 1'b1);
    cfg_d = '0;
    cfg_d[98] = 1'b1;
    a5 = 48'hA5A5_A5A5_A5A5;

    m_cfg = 'x;
    m_pd = 1'b0; m_pbd = 1'b0; m_pdp = 1'b0; m_pbdp = 1'b0;
    cur_p = '0; cur_c = '0; cur_cep = 1'b1; cur_rstn = 1'b0; cur_preg = 1'b1;
    inter_P = '0; C = '0; CEP = 1'b1; RSTN = 1'b0; PREG = 1'b1;
    configuration_enable = 1'b0; configuration_input = 1'b0;

    // Initial load under reset; config contents unknown until complete
    load_cfg(cfg_a, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk_all_zero("reset");
    cur_rstn = 1'b1;

    // Registered match, then history and overflow
    cur_p = 48'h0000_0000_0005; cyc(1'b0, 1'b0, 1'b1);
    chk("t1_raw", PATDET_RAW, 1'b1);
    chk("t1_pd_next", PATTERNDETECT, 1'b1);
    cur_p = 48'h4000_0000_0000; cyc(1'b0, 1'b0, 1'b1);
    chk("t1_past", PATTERNDETECTPAST, 1'b1);

    cur_p = 48'h0000_0000_0001; cyc(1'b0, 1'b0, 1'b1);
    cur_p = 48'h4000_0000_0000; cyc(1'b0, 1'b0, 1'b1);
    chk("t2_ovf_set", OVERFLOW, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t2_ovf_clr", OVERFLOW, 1'b0);
    cur_p = 48'hFFFF_FFFF_FFFF; cyc(1'b0, 1'b0, 1'b1);
    chk("t2_pbd", PATTERNBDETECT, 1'b1);
    cur_p = 48'hBFFF_FFFF_FFFF; cyc(1'b0, 1'b0, 1'b1);
    chk("t2_udf_set", UNDERFLOW, 1'b1);
    cur_p = 48'h4000_0000_0000; cyc(1'b0, 1'b0, 1'b1);
    chk("t2_udf_clr", UNDERFLOW, 1'b0);

    // Dynamic pattern from C, combinational mode
    cur_preg = 1'b0;
    load_cfg(cfg_b, 1'b1);
    cur_p = a5; cur_c = a5; cyc(1'b0, 1'b0, 1'b1);
    chk("t3_pd_raw", PATDET_RAW, 1'b1);
    chk("t3_pbd_raw", PATBDET_RAW, 1'b0);
    chk("t3_pd_comb", PATTERNDETECT, 1'b1);
    cur_c = ~a5; cyc(1'b0, 1'b0, 1'b1);
    chk("t3_inv_pbd", PATBDET_RAW, 1'b1);
    chk("t3_inv_pd", PATDET_RAW, 1'b0);

    // Dynamic mask from C: all ones masks everything, both flags set
    load_cfg(cfg_c, 1'b1);
    cur_c = '1; cur_p = 48'h1234_5678_9ABC; cyc(1'b0, 1'b0, 1'b1);
    chk("t3m_both_pd", PATDET_RAW, 1'b1);
    chk("t3m_both_pbd", PATBDET_RAW, 1'b1);
    cur_c = 48'hFFFF_FFFF_FFFE; cur_p = '0; cyc(1'b0, 1'b0, 1'b1);
    chk("t3m_lsb_pd", PATDET_RAW, 1'b1);
    chk("t3m_lsb_pbd", PATBDET_RAW, 1'b0);

    // Clock-enable hold, then reset overriding CEP
    load_cfg(cfg_a, 1'b1);
    cur_preg = 1'b1; cur_c = '0;
    cur_p = 48'h0000_0000_0005; cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b1);
    chk("t4_pd_set", PATTERNDETECT, 1'b1);
    cur_cep = 1'b0; cur_p = 48'h4000_0000_0000;
    for (int unsigned k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("t4_pd_hold", PATTERNDETECT, 1'b1);
    end
    cur_preg = 1'b0; cyc(1'b0, 1'b0, 1'b1);
    chk("t4_preg_comb", PATTERNDETECT, 1'b0);
    cur_preg = 1'b1;
    cur_cep = 1'b1; cur_rstn = 1'b0; cyc(1'b0, 1'b0, 1'b1);
    chk_all_zero("t4_rst");
    cur_rstn = 1'b1; cyc(1'b0, 1'b0, 1'b1);
    chk("t4_no_ovf_after_rst", OVERFLOW, 1'b0);

    // Single 1 through the full chain; USE ends up 0
    load_cfg(cfg_d, 1'b1);
    chk("t5_cfg_out", configuration_output, 1'b1);
    cur_preg = 1'b0;
    cur_p = 48'h0000_0000_0005; cyc(1'b0, 1'b0, 1'b1);
    chk("t5_use0_pd", PATDET_RAW, 1'b0);
    chk("t5_use0_track", PATTERNDETECT, 1'b0);
    cur_p = '1; cyc(1'b0, 1'b0, 1'b1);
    chk("t5_use0_pbd", PATBDET_RAW, 1'b0);
    for (int unsigned k = 0; k < 4; k++) begin
      cur_p = {$urandom(), $urandom_range(65535, 0)};
      cur_c = {$urandom(), $urandom_range(65535, 0)};
      cyc(1'b0, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
